// File: rtl/glb_write.sv
`default_nettype none
// ============================================================================
//  Module   : glb_write
//  Purpose  : Streams the preloaded contents of one or two block memories as
//             framed blocks. Each block is framed as a header word holding the
//             effective word count, followed by that many words read from
//             address 0 upward. A valid/ready handshake paces the stream.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   single clock, rising-edge
//    rst_n        in   synchronous reset, ACTIVE-HIGH despite the name
//    flush        in   starts a transfer when the FSM is in IDLE or DONE
//    data         out  stream word (registered)
//    valid        out  stream valid (registered)
//    ready        in   downstream ready
//    done         out  every block has been sent (registered)
//    cfg_size_0   in   word count of block 0
//    cfg_size_1   in   word count of block 1 (ignored when NUM_BLOCKS = 1)
//    wr_en        in   memory preload strobe (honoured in IDLE/DONE only)
//    wr_blk       in   preload target block
//    wr_addr      in   preload word address
//    wr_data      in   preload word
// ============================================================================
module glb_write #(
  parameter int NUM_BLOCKS = 1,
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  output logic [DATA_WIDTH-1:0]    data,
  output logic                     valid,
  input  logic                     ready,
  output logic                     done,
  input  logic [DATA_WIDTH-1:0]    cfg_size_0,
  input  logic [DATA_WIDTH-1:0]    cfg_size_1,
  input  logic                     wr_en,
  input  logic                     wr_blk,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data
);

  localparam int AW = $clog2(DEPTH);
  // One extra bit lets a count of exactly DEPTH be held without wrapping.
  localparam int CW = AW + 1;
  localparam logic [DATA_WIDTH-1:0] c_DEPTH_W = DATA_WIDTH'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_blk, w_blk_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [CW-1:0]         r_size0, w_size0_nxt;
  logic [CW-1:0]         r_size1, w_size1_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_blk_end;

  logic [CW-1:0]         w_eff0, w_eff1, w_cur_size;
  logic [AW-1:0]         w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rd0, w_rd1, w_rd;
  logic                  w_hs;
  logic                  w_wr_ok;

  assign data  = r_data;
  assign valid = r_valid;
  assign done  = r_done;

  assign w_hs = r_valid & ready;

  // Sizes are clamped to the memory depth and latched at the flush edge.
  assign w_eff0 = (cfg_size_0 > c_DEPTH_W) ? CW'(DEPTH) : CW'(cfg_size_0);
  assign w_eff1 = (cfg_size_1 > c_DEPTH_W) ? CW'(DEPTH) : CW'(cfg_size_1);
  assign w_cur_size = r_blk ? r_size1 : r_size0;

  // r_cnt is the index of the next data word to present: it is 0 while the
  // header is on the bus, and k while word k-1 is on the bus.
  assign w_rd_addr = r_cnt[AW-1:0];
  assign w_rd      = r_blk ? w_rd1 : w_rd0;

  // Preload is allowed only while no transfer is in flight and not in reset.
  assign w_wr_ok = wr_en & ~rst_n & ((r_state == S_IDLE) | (r_state == S_DONE));

  // --------------------------------------------------------------------------
  // Block memories (never reset; contents survive rst_n)
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem0 [DEPTH];

  always_ff @(posedge clk) begin
    if (w_wr_ok && !wr_blk) begin
      r_mem0[wr_addr] <= wr_data;
    end
  end

  assign w_rd0 = r_mem0[w_rd_addr];

  generate
    if (NUM_BLOCKS == 2) begin : g_blk1
      logic [DATA_WIDTH-1:0] r_mem1 [DEPTH];

      always_ff @(posedge clk) begin
        if (w_wr_ok && wr_blk) begin
          r_mem1[wr_addr] <= wr_data;
        end
      end

      assign w_rd1 = r_mem1[w_rd_addr];
    end else begin : g_no_blk1
      assign w_rd1 = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM: next-state and registered-output computation
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_blk_nxt   = r_blk;
    w_cnt_nxt   = r_cnt;
    w_size0_nxt = r_size0;
    w_size1_nxt = r_size1;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    w_blk_end   = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (flush) begin
          w_state_nxt = S_HDR;
          w_blk_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_size0_nxt = w_eff0;
          w_size1_nxt = (NUM_BLOCKS == 2) ? w_eff1 : '0;
          w_data_nxt  = DATA_WIDTH'(w_eff0);
          w_valid_nxt = 1'b1;
          w_done_nxt  = 1'b0;
        end
      end
      S_HDR: begin
        if (w_hs) begin
          if (w_cur_size == '0) begin
            w_blk_end = 1'b1;
          end else begin
            w_state_nxt = S_DATA;
            w_data_nxt  = w_rd;
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (w_hs) begin
          if (r_cnt == w_cur_size) begin
            w_blk_end = 1'b1;
          end else begin
            w_data_nxt = w_rd;
            w_cnt_nxt  = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Block boundary: either move straight to the next header (no bubble) or
    // finish the transfer.
    if (w_blk_end) begin
      w_cnt_nxt = '0;
      if ((NUM_BLOCKS == 2) && !r_blk) begin
        w_state_nxt = S_HDR;
        w_blk_nxt   = 1'b1;
        w_data_nxt  = DATA_WIDTH'(r_size1);
      end else begin
        w_state_nxt = S_DONE;
        w_data_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S_IDLE;
      r_blk   <= 1'b0;
      r_cnt   <= '0;
      r_size0 <= '0;
      r_size1 <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_blk   <= w_blk_nxt;
      r_cnt   <= w_cnt_nxt;
      r_size0 <= w_size0_nxt;
      r_size1 <= w_size1_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_glb_write.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glb_write
//  Purpose  : Self-checking bench for glb_write. Two instances are exercised:
//             u1 (one block, DEPTH 1024) and u2 (two blocks, DEPTH 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_glb_write;

  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] cfg_size_0 = '0;
  logic [15:0] cfg_size_1 = '0;
  logic        wr_en1 = 1'b0;
  logic        wr_en2 = 1'b0;
  logic        wr_blk = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;

  logic [15:0] data1, data2;
  logic        valid1, valid2, done1, done2;

  always #5 clk = ~clk;

  glb_write #(.NUM_BLOCKS(1), .DEPTH(1024), .DATA_WIDTH(16)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data(data1), .valid(valid1),
    .ready(ready), .done(done1), .cfg_size_0(cfg_size_0),
    .cfg_size_1(cfg_size_1), .wr_en(wr_en1), .wr_blk(wr_blk),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  glb_write #(.NUM_BLOCKS(2), .DEPTH(8), .DATA_WIDTH(16)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data(data2), .valid(valid2),
    .ready(ready), .done(done2), .cfg_size_0(cfg_size_0),
    .cfg_size_1(cfg_size_1), .wr_en(wr_en2), .wr_blk(wr_blk),
    .wr_addr(wr_addr[2:0]), .wr_data(wr_data)
  );

  int          sel = 1;
  logic [15:0] s_data;
  logic        s_valid, s_done;
  assign s_data  = (sel == 2) ? data2  : data1;
  assign s_valid = (sel == 2) ? valid2 : valid1;
  assign s_done  = (sel == 2) ? done2  : done1;

  // Reference memory images
  logic [15:0] m1 [1024];
  logic [15:0] m2 [2][8];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    int          dut;
    int          size0;
    int          size1;
    logic [31:0] rpat;   // ready pattern, bit n used on stream cycle n%32
    int          inj;    // stream cycle for a flush + write poke, -1 = none
    int          hdr0;   // expected header of block 0
    int          hdr1;   // expected header of block 1 (dut 2 only)
  } vec_t;

  vec_t tbl [9];

  task automatic put(input int dut, input logic blk, input int addr, input logic [15:0] val);
    wr_blk  = blk;
    wr_addr = 10'(addr);
    wr_data = val;
    if (dut == 1) begin
      wr_en1 = 1'b1;
      if (!blk) m1[addr] = val;
    end else begin
      wr_en2 = 1'b1;
      m2[blk][addr % 8] = val;
    end
    @(negedge clk);
    wr_en1 = 1'b0;
    wr_en2 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic run(input vec_t v, input string tag);
    logic [15:0] got [$];
    logic [15:0] exp [$];
    logic [15:0] pdata;
    bit          stall;
    int          cyc;
    int          holderr;
    int          dataerr;
    int          firstbad;

    exp.push_back(16'(v.hdr0));
    for (int i = 0; i < v.hdr0; i++)
      exp.push_back((v.dut == 1) ? m1[i] : m2[0][i]);
    if (v.dut == 2) begin
      exp.push_back(16'(v.hdr1));
      for (int i = 0; i < v.hdr1; i++) exp.push_back(m2[1][i]);
    end

    sel = v.dut;
    @(negedge clk);
    cfg_size_0 = 16'(v.size0);
    cfg_size_1 = 16'(v.size1);
    ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk({tag, " start_valid_done"}, {30'd0, s_valid, s_done}, 32'h2);

    cyc = 0; holderr = 0; stall = 1'b0; pdata = '0;
    while (cyc < BUDGET) begin
      if (!s_valid) break;
      if (stall && s_data !== pdata) holderr++;
      // Configuration changes after the flush edge must not matter.
      if (cyc == 1) begin
        cfg_size_0 = 16'h0001;
        cfg_size_1 = 16'h0007;
      end
      if (cyc == v.inj) begin
        flush = 1'b1; wr_en1 = 1'b1; wr_blk = 1'b0;
        wr_addr = 10'd1; wr_data = 16'hBEEF;
      end else begin
        flush = 1'b0; wr_en1 = 1'b0;
      end
      ready = v.rpat[cyc % 32];
      if (ready) got.push_back(s_data);
      stall = !ready;
      pdata = s_data;
      @(negedge clk);
      cyc++;
    end
    flush = 1'b0; wr_en1 = 1'b0; ready = 1'b0;

    chk({tag, " no_timeout"}, (cyc < BUDGET) ? 32'd1 : 32'd0, 32'd1);
    chk({tag, " word_count"}, got.size(), exp.size());
    dataerr = 0; firstbad = 0;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      if (got[i] !== exp[i]) begin
        if (dataerr == 0) firstbad = i;
        dataerr++;
      end
    end
    if (dataerr != 0)
      $display("  first bad word %0d: got 0x%0h expected 0x%0h", firstbad, got[firstbad], exp[firstbad]);
    chk({tag, " stream_data_errors"}, dataerr, 0);
    chk({tag, " hold_while_stalled_errors"}, holderr, 0);
    if (v.rpat == 32'hFFFF_FFFF)
      chk({tag, " valid_cycles_no_bubble"}, cyc, exp.size());
    chk({tag, " end_valid_done"}, {30'd0, s_valid, s_done}, 32'h1);
    repeat (3) @(negedge clk);
    chk({tag, " done_sticky"}, {30'd0, s_valid, s_done}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            dut size0    size1 rpat          inj hdr0    hdr1
    tbl[0] = '{1, 4,       0,  32'hFFFF_FFFF, -1, 4,      0};
    tbl[1] = '{1, 4,       0,  32'h9999_9999, -1, 4,      0};
    tbl[2] = '{2, 2,       0,  32'hFFFF_FFFF, -1, 2,      0};
    tbl[3] = '{1, 16'h500, 0,  32'hFFFF_FFFF, -1, 16'h400, 0};
    tbl[4] = '{2, 3,       20, 32'hA5A5_A5A5, -1, 3,      8};
    tbl[5] = '{1, 0,       0,  32'hFFFF_FFFF, -1, 0,      0};
    tbl[6] = '{2, 0,       0,  32'h6DB6_DB6D, -1, 0,      0};
    tbl[7] = '{1, 4,       0,  32'h9999_9999, 2,  4,      0};
    tbl[8] = '{1, 4,       0,  32'hFFFF_FFFF, -1, 4,      0};

    do_reset();
    chk("reset u1 data/valid/done", {valid1, done1, data1}, 0);
    chk("reset u2 data/valid/done", {valid2, done2, data2}, 0);

    for (int i = 0; i < 1024; i++)
      put(1, 1'b0, i, (i < 4) ? 16'(16'hA0 + i) : 16'(16'h5000 + i));
    // Block 1 writes into a single-block instance must be discarded.
    put(1, 1'b1, 0, 16'hFFFF);
    put(1, 1'b1, 1, 16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      put(2, 1'b0, i, (i < 2) ? 16'(16'h11 + i) : 16'(16'h20 + i));
      put(2, 1'b1, i, 16'(16'h30 + i));
    end

    for (int i = 0; i < 9; i++) begin
      do_reset();
      run(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset mid-transfer after the third handshake, with flush and a write
    // presented during the reset cycle.
    do_reset();
    sel = 1;
    @(negedge clk);
    cfg_size_0 = 16'd4;
    ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset word_before_reset", {15'd0, valid1, data1}, {15'd0, 1'b1, 16'hA2});
    rst_n = 1'b1; flush = 1'b1;
    wr_en1 = 1'b1; wr_blk = 1'b0; wr_addr = 10'd0; wr_data = 16'hDEAD;
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; wr_en1 = 1'b0; ready = 1'b0;
    chk("midreset after_reset data/valid/done", {valid1, done1, data1}, 0);
    @(negedge clk);
    chk("midreset still_idle", {30'd0, valid1, done1}, 0);
    run(tbl[0], "replay");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/glb_write.md
GLB_WRITE -- requirements
Module: glb_write

Interface
REQ-001 Parameter NUM_BLOCKS, default 1, SHALL be the number of blocks streamed per flush; legal values are 1 and 2.
REQ-002 Parameter DEPTH, default 1024, SHALL be the words per block memory.
REQ-003 Parameter DATA_WIDTH, default 16, SHALL be the stream and memory word width.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: synchronous and active-high, asserted high despite the name.
REQ-006 flush  input  1  SHALL start a transfer when sampled high in IDLE or DONE.
REQ-007 data  output  DATA_WIDTH  SHALL be the stream word, registered.
REQ-008 valid  output  1  SHALL be the stream valid, registered.
REQ-009 ready  input  1  SHALL be the downstream ready.
REQ-010 done  output  1  SHALL indicate all blocks sent, registered.
REQ-011 cfg_size_0, cfg_size_1  input  DATA_WIDTH each  SHALL be the word counts of blocks 0 and 1.
REQ-012 wr_en, wr_blk (1), wr_addr (log2 DEPTH), wr_data (DATA_WIDTH)  inputs  SHALL form the memory preload port.

Function
REQ-013 Stream format per block SHALL be one header word equal to the effective size, then that many data words from addresses 0..size-1 in order; block 0 precedes block 1.
REQ-014 Effective size SHALL be min(cfg_size_n, DEPTH), captured at the flush edge; later cfg changes SHALL NOT affect the transfer in progress.
REQ-015 FSM states SHALL be IDLE, HDR, DATA, DONE.
REQ-016 IDLE/DONE + flush -> HDR; valid=1 and data=size_0 SHALL be presented the cycle after the flush edge; done SHALL clear on the same edge.
REQ-017 A handshake SHALL occur at an edge where valid=1 and ready=1; only handshakes SHALL advance the stream.
REQ-018 While valid=1 and ready=0, data and valid SHALL hold stable.
REQ-019 HDR handshake -> DATA with next word presented the following cycle; if size=0, the block SHALL end at the header handshake.
REQ-020 DATA handshake of word size-1 SHALL end the block.
REQ-021 Block end with further blocks remaining -> HDR of the next block, header presented the following cycle.
REQ-022 Block end on the last block -> DONE; the following cycle SHALL show valid=0 and done=1.
REQ-023 With ready held high, throughput SHALL be one word per cycle with no bubbles, including across block boundaries.
REQ-024 done SHALL stay 1 in DONE until reset or flush.
REQ-025 flush SHALL be ignored in HDR and DATA.
REQ-026 wr_en SHALL write wr_data to memory[wr_blk][wr_addr] only in IDLE or DONE; writes in HDR/DATA SHALL be dropped.
REQ-027 With NUM_BLOCKS=1, cfg_size_1 and writes with wr_blk=1 SHALL be ignored.
REQ-028 The word counter SHALL be log2(DEPTH)+1 bits wide so a size of DEPTH completes without wrap-around.

Reset
REQ-029 rst_n high at an edge SHALL force IDLE, valid=0, data=0, done=0, and counters=0, including mid-transfer.
REQ-030 Reset SHALL NOT clear memory contents; flush and wr_en SHALL be ignored in the reset cycle.

Verification
REQ-031 NUM_BLOCKS=1, preload 0xA0..0xA3, size_0=4, ready=1, flush pulse -> valid 5 consecutive cycles carrying 4,A0,A1,A2,A3, then done=1.
REQ-032 Same setup, ready toggled 1,0,0,1,... -> identical word sequence; data stable during every ready=0 cycle.
REQ-033 NUM_BLOCKS=2, size_0=2 (11,12), size_1=0 -> stream 2,11,12,0 back-to-back, then done.
REQ-034 size_0=0x0500 with DEPTH=1024 -> header 0x0400, then exactly 1024 words, then done.
REQ-035 Reset asserted after the third handshake -> next cycle valid=0, done=0; a new flush replays from the header with unchanged memory contents.
REQ-036 flush during DATA and wr_en during DATA -> stream unaffected; memory unchanged on the next flush.
